// File: rtl/aud_dsp_v2.sv
// aud_dsp_v2: SRAM sample playback to a DAC with fast, slow-hold and slow-linear speed modes. Defining AUD_DSP_REVERSE_EN adds reverse play through the i_reverse input.
module aud_dsp_v2 #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int SPEED_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sample_tick,
    input  logic                     i_start,
    input  logic                     i_pause,
    input  logic                     i_stop,
    input  logic [1:0]               i_mode,
    input  logic [SPEED_W-1:0]       i_speed,
    input  logic [ADDR_W-1:0]        i_end_addr,
`ifdef AUD_DSP_REVERSE_EN
    input  logic                     i_reverse,
`endif
    input  logic signed [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0]        o_sram_addr,
    output logic signed [DATA_W-1:0] o_dac_data,
    output logic                     o_dac_valid,
    output logic                     o_busy,
    output logic                     o_finished
);
    localparam int PW = DATA_W + SPEED_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t                   state, state_n;
    logic [1:0]               mode_r, mode_n;
    logic [SPEED_W-1:0]       spd_r, spd_n, k_r, k_n, spd_in;
    logic signed [DATA_W-1:0] prev_r, prev_n, data_n, interp;
    logic [ADDR_W-1:0]        addr_n;
    logic                     valid_n, fin_n, rev_r, rev_n, rev_in, slow, past_end;
    logic [ADDR_W:0]          step, nxt;
    logic signed [PW-1:0]     diff, prod, quo;

`ifdef AUD_DSP_REVERSE_EN
    assign rev_in = i_reverse;
`else
    assign rev_in = 1'b0;
`endif

    assign spd_in = (i_speed == '0) ? SPEED_W'(1) : i_speed;
    assign slow   = (mode_r == 2'd1) || (mode_r == 2'd2);
    assign o_busy = (state == RUN) || (state == PAUSE);

    // Next address is evaluated one bit wider so running off either end is seen instead of wrapping
    assign step     = slow ? (ADDR_W+1)'(1) : (ADDR_W+1)'(spd_r);
    assign nxt      = rev_r ? {1'b0, o_sram_addr} - step : {1'b0, o_sram_addr} + step;
    assign past_end = rev_r ? nxt[ADDR_W] : (nxt > {1'b0, i_end_addr});

    // Interpolation is wide enough for the full difference times k; the quotient always lies between the two samples
    assign diff   = PW'(i_sram_data) - PW'(prev_r);
    assign prod   = diff * $signed(PW'(k_r));
    assign quo    = prod / $signed(PW'(spd_r));
    assign interp = prev_r + DATA_W'(quo);

    // Next-state and next-output decode; a tick coinciding with a pause is swallowed by the pause
    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        spd_n   = spd_r;
        rev_n   = rev_r;
        k_n     = k_r;
        prev_n  = prev_r;
        data_n  = o_dac_data;
        addr_n  = o_sram_addr;
        valid_n = 1'b0;
        fin_n   = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                state_n = RUN;
                mode_n  = i_mode;
                spd_n   = spd_in;
                rev_n   = rev_in;
                addr_n  = rev_in ? i_end_addr : '0;
                k_n     = '0;
                prev_n  = '0;
            end
            RUN: if (i_stop) begin
                state_n = IDLE;
                addr_n  = '0;
                data_n  = '0;
            end else if (i_pause) begin
                state_n = PAUSE;
            end else if (i_sample_tick) begin
                valid_n = 1'b1;
                if (!slow || k_r == '0) begin
                    data_n = i_sram_data;
                    if (slow) prev_n = i_sram_data;
                    k_n = (slow && spd_r != SPEED_W'(1)) ? SPEED_W'(1) : '0;
                    if (past_end) state_n = DONE;
                    else addr_n = nxt[ADDR_W-1:0];
                end else begin
                    data_n = (mode_r == 2'd2) ? interp : prev_r;
                    k_n    = (k_r == spd_r - SPEED_W'(1)) ? '0 : k_r + SPEED_W'(1);
                end
            end
            PAUSE: if (i_stop) begin
                state_n = IDLE;
                addr_n  = '0;
                data_n  = '0;
            end else if (i_pause) begin
                state_n = RUN;
                mode_n  = i_mode;
                spd_n   = spd_in;
                rev_n   = rev_in;
                k_n     = '0;
            end
            DONE: begin
                state_n = IDLE;
                data_n  = '0;
                addr_n  = '0;
                fin_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset forces the silent idle condition immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            mode_r      <= 2'd0;
            spd_r       <= SPEED_W'(1);
            rev_r       <= 1'b0;
            k_r         <= '0;
            prev_r      <= '0;
            o_dac_data  <= '0;
            o_sram_addr <= '0;
            o_dac_valid <= 1'b0;
            o_finished  <= 1'b0;
        end else begin
            state       <= state_n;
            mode_r      <= mode_n;
            spd_r       <= spd_n;
            rev_r       <= rev_n;
            k_r         <= k_n;
            prev_r      <= prev_n;
            o_dac_data  <= data_n;
            o_sram_addr <= addr_n;
            o_dac_valid <= valid_n;
            o_finished  <= fin_n;
        end
    end
endmodule

// File: tb/tb_aud_dsp_v2.sv
// tb_aud_dsp_v2: random playback runs checked against a sample-list reference model, plus directed corner cases
module tb_aud_dsp_v2;
    localparam int DATA_W = 16, ADDR_W = 20, SPEED_W = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic tick = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [SPEED_W-1:0] speed = '0;
    logic [ADDR_W-1:0] end_addr = '0;
`ifdef AUD_DSP_REVERSE_EN
    logic reverse = 1'b0;
`endif
    logic signed [DATA_W-1:0] sram_data, dac_data;
    logic [ADDR_W-1:0] sram_addr;
    logic dac_valid, busy, finished;
    int mem [256];
    int n_chk = 0, n_err = 0;

    assign sram_data = DATA_W'(mem[sram_addr[7:0]]);

    always #5 clk = ~clk;

    aud_dsp_v2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SPEED_W(SPEED_W)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_sample_tick(tick),
        .i_start(start),
        .i_pause(pause),
        .i_stop(stop),
        .i_mode(mode),
        .i_speed(speed),
        .i_end_addr(end_addr),
`ifdef AUD_DSP_REVERSE_EN
        .i_reverse(reverse),
`endif
        .i_sram_data(sram_data),
        .o_sram_addr(sram_addr),
        .o_dac_data(dac_data),
        .o_dac_valid(dac_valid),
        .o_busy(busy),
        .o_finished(finished)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 256; i++) mem[i] = i;
    endtask

    // Plays one clip with random tick spacing; the model lists every DAC sample and the address that follows it
    task automatic play(input int md, input int sp, input int ea, input bit do_pause);
        int s, cyc, pause_at, last_d, last_a;
        int exp_d[$], exp_a[$];
        bit fin;
        s = (sp == 0) ? 1 : sp;
        if (md == 1 || md == 2) begin
            for (int a = 0; a <= ea; a++) begin
                exp_d.push_back(mem[a]);
                exp_a.push_back(a < ea ? a + 1 : a);
                if (a < ea)
                    for (int k = 1; k < s; k++) begin
                        exp_d.push_back(md == 1 ? mem[a] : mem[a] + (mem[a+1] - mem[a]) * k / s);
                        exp_a.push_back(a + 1);
                    end
            end
        end else begin
            for (int a = 0; a <= ea; a += s) begin
                exp_d.push_back(mem[a]);
                exp_a.push_back(a + s <= ea ? a + s : a);
            end
        end
        pause_at = (do_pause && md != 1 && md != 2) ? int'($urandom_range(1, 6)) : -1;
        last_d = 0;
        last_a = 0;
        @(negedge clk);
        mode = 2'(md);
        speed = SPEED_W'(sp);
        end_addr = ADDR_W'(ea);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 4000) begin
            if (cyc == pause_at && busy) begin
                tick = 1'b0;
                pause = 1'b1;
                @(negedge clk);
                pause = 1'b0;
                chk("busy_paused", busy, 1);
                for (int i = 0; i < 4; i++) begin
                    tick = 1'b1;
                    @(posedge clk);
                    #1;
                    chk("valid_paused", dac_valid, 0);
                    chk("data_paused", dac_data, last_d);
                    chk("addr_paused", sram_addr, last_a);
                    @(negedge clk);
                end
                tick = 1'b0;
                pause = 1'b1;
                @(negedge clk);
                pause = 1'b0;
            end
            tick = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            if (dac_valid) begin
                chk("valid_expected", int'(exp_d.size() > 0), 1);
                if (exp_d.size() > 0) begin
                    last_d = exp_d.pop_front();
                    last_a = exp_a.pop_front();
                    chk("data", dac_data, last_d);
                    chk("addr", sram_addr, last_a);
                end
            end
            fin = finished;
            cyc++;
            @(negedge clk);
        end
        tick = 1'b0;
        chk("finished_seen", fin, 1);
        chk("samples_left", exp_d.size(), 0);
        chk("data_idle", dac_data, 0);
        chk("addr_idle", sram_addr, 0);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        #1;
        chk("finished_one_cycle", finished, 0);
        @(negedge clk);
    endtask

    initial begin
        int cyc, nv;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nv;
        fill_ramp();
        repeat (3) @(negedge clk);
        chk("rst_data", dac_data, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_valid", dac_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        rst_n = 1'b1;
        @(negedge clk);

        play(0, 4, 15, 0);
        mem[0] = 0;
        mem[1] = 100;
        mem[2] = 100;
        play(2, 4, 2, 0);
        mem[1] = -7;
        play(2, 3, 1, 0);
        play(1, 4, 3, 0);
        fill_ramp();
        play(3, 0, 6, 1);

        @(negedge clk);
        mode = 2'd0;
        speed = SPEED_W'(1);
        end_addr = ADDR_W'(200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            tick = 1'b1;
            @(negedge clk);
        end
        chk("addr_before_stop", sram_addr, 5);
        pause = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_addr", sram_addr, 0);
        chk("stop_data", dac_data, 0);
        nv = 0;
        repeat (20) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            nv += int'(dac_valid);
            @(negedge clk);
        end
        tick = 1'b0;
        chk("valid_after_stop", nv, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick = 1'b1;
        cyc = 0;
        while (sram_addr != ADDR_W'(37) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_37", sram_addr, 37);
        #1;
        rst_n = 1'b0;
        #1;
        tick = 1'b0;
        chk("async_rst_data", dac_data, 0);
        chk("async_rst_addr", sram_addr, 0);
        chk("async_rst_valid", dac_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_finished", finished, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_in_rst_dropped", busy, 0);
        play(0, 1, 40, 0);

`ifdef AUD_DSP_REVERSE_EN
        begin
            int got[$];
            bit fin;
            @(negedge clk);
            mode = 2'd0;
            speed = SPEED_W'(2);
            end_addr = ADDR_W'(5);
            reverse = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("rev_start_addr", sram_addr, 5);
            tick = 1'b1;
            fin = 1'b0;
            cyc = 0;
            while (!fin && cyc < 100) begin
                @(posedge clk);
                #1;
                if (dac_valid) got.push_back(int'(dac_data));
                fin = finished;
                cyc++;
            end
            tick = 1'b0;
            reverse = 1'b0;
            chk("rev_finished", fin, 1);
            chk("rev_count", got.size(), 3);
            for (int i = 0; i < got.size() && i < 3; i++) chk("rev_sample", got[i], 5 - 2 * i);
            @(negedge clk);
        end
`endif

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(0, 65535)) - 32768;
            play(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 30)), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
